// File: rtl/ext_uart_bridge_pkg.sv
// rtl/ext_uart_bridge_pkg.sv - shared UART state encodings and constants
package ext_uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/ext_uart_fifo.sv
// rtl/ext_uart_fifo.sv - first-word-fall-through RX byte FIFO with registered head and overrun pulse
module ext_uart_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       overrun
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_next;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_next;
  logic               do_push;
  logic               do_pop;

  assign full = (count == (FIFO_AW+1)'(DEPTH));

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    do_pop     = pop && (count != '0);
    do_push    = push && (!full || do_pop);
    rd_next    = rd_ptr + FIFO_AW'(do_pop);
    count_next = count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // The head register bypasses memory when the incoming byte becomes the new head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dout    <= 8'h00;
      empty   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_next;
      count   <= count_next;
      empty   <= (count_next == '0);
      overrun <= push && !do_push;
      if (count_next == '0) begin
        dout <= 8'h00;
      end else if (do_push && (rd_next == wr_ptr)) begin
        dout <= din;
      end else begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/ext_uart_bridge.sv
// rtl/ext_uart_bridge.sv - EXT port to 8N1 UART bridge: TX serialiser, RX deserialiser and RX FIFO
module ext_uart_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] cd,
  output logic       crda,
  input  logic       cack,
  input  logic [7:0] cq,
  input  logic       cwre,
  output logic       cbsy,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  import ext_uart_bridge_pkg::*;

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t                tx_state, tx_state_next;
  logic [CNT_W-1:0]           tx_cnt, tx_cnt_next;
  logic [2:0]                 tx_bit, tx_bit_next;
  logic [UART_DATA_BITS-1:0]  tx_shift, tx_shift_next;
  logic                       tx_last;
  logic                       txd_next;
  logic                       cbsy_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      cbsy     <= 1'b0;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      tx_shift <= tx_shift_next;
      txd      <= txd_next;
      cbsy     <= cbsy_next;
    end
  end

  // Writes outside IDLE fall through the default and leave the shift register alone.
  always_comb begin
    tx_last       = (tx_cnt == LAST);
    tx_state_next = tx_state;
    tx_cnt_next   = tx_last ? '0 : tx_cnt + 1'b1;
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_next = '0;
        if (cwre) begin
          tx_state_next = ST_START;
          tx_shift_next = cq;
        end
      end
      ST_START: if (tx_last) tx_state_next = ST_DATA;
      ST_DATA: begin
        if (tx_last) begin
          tx_bit_next   = tx_bit + 1'b1;
          tx_shift_next = {1'b0, tx_shift[UART_DATA_BITS-1:1]};
          if (tx_bit == LAST_BIT) tx_state_next = ST_STOP;
        end
      end
      ST_STOP: if (tx_last) tx_state_next = ST_IDLE;
      default: tx_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cbsy_next = (tx_state_next != ST_IDLE);
    case (tx_state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = tx_shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  uart_state_t                rx_state, rx_state_next;
  logic [CNT_W-1:0]           rx_cnt, rx_cnt_next;
  logic [2:0]                 rx_bit, rx_bit_next;
  logic [UART_DATA_BITS-1:0]  rx_shift, rx_shift_next;
  logic                       rx_s1, rx_s2, rx_prev;
  logic                       rx_last;
  logic                       rx_push;
  logic                       frame_err_next;
  logic                       rx_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= ST_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= rxd;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_state     <= rx_state_next;
      rx_cnt       <= rx_cnt_next;
      rx_bit       <= rx_bit_next;
      rx_shift     <= rx_shift_next;
      rx_frame_err <= frame_err_next;
    end
  end

  // Half a bit into START puts every later full-bit sample near mid-bit.
  always_comb begin
    rx_last       = (rx_cnt == LAST);
    rx_state_next = rx_state;
    rx_cnt_next   = rx_last ? '0 : rx_cnt + 1'b1;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    case (rx_state)
      ST_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev && !rx_s2) rx_state_next = ST_START;
      end
      ST_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_next   = '0;
          rx_state_next = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_last) begin
          rx_shift_next = {rx_s2, rx_shift[UART_DATA_BITS-1:1]};
          rx_bit_next   = rx_bit + 1'b1;
          if (rx_bit == LAST_BIT) rx_state_next = ST_STOP;
        end
      end
      ST_STOP: if (rx_last) rx_state_next = ST_IDLE;
      default: rx_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_push        = (rx_state == ST_STOP) && rx_last && rx_s2;
    frame_err_next = (rx_state == ST_STOP) && rx_last && !rx_s2;
  end

  ext_uart_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push),
    .din     (rx_shift),
    .full    (),
    .pop     (cack),
    .dout    (cd),
    .empty   (rx_empty),
    .overrun (rx_overrun)
  );

  assign crda = ~rx_empty;

endmodule

// File: tb/tb_ext_uart_bridge.sv
// tb/tb_ext_uart_bridge.sv - directed self-checking bench for ext_uart_bridge
module tb_ext_uart_bridge;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cd;
  logic       crda;
  logic       cack = 1'b0;
  logic [7:0] cq = 8'h00;
  logic       cwre = 1'b0;
  logic       cbsy;
  logic       rxd = 1'b1;
  logic       txd;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_pass = 0;
  int n_total = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  logic [7:0] rx_exp[$];
  logic       tx_exp[$];

  always #5 clk = ~clk;

  ext_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cd           (cd),
    .crda         (crda),
    .cack         (cack),
    .cq           (cq),
    .cwre         (cwre),
    .cbsy         (cbsy),
    .rxd          (rxd),
    .txd          (txd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always @(negedge clk) begin
    if (rx_overrun === 1'b1) ovr_cnt++;
    if (rx_frame_err === 1'b1) ferr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic expect_push);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (expect_push) rx_exp.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    int w;
    logic [7:0] e;
    w = 0;
    while (crda !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    chk({tag, "_crda"}, 32'(crda), 32'd1);
    e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hEE;
    chk({tag, "_cd"}, 32'(cd), 32'(e));
    cack = 1'b1;
    tick();
    cack = 1'b0;
  endtask

  initial begin
    logic       busy;
    logic       cur;
    logic [9:0] f;
    int         w;

    reset = 1'b0; rxd = 1'b1; cwre = 1'b1; cq = 8'h41;
    repeat (3) tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_cbsy", 32'(cbsy), 32'd0);
    chk("rst_crda", 32'(crda), 32'd0);
    chk("rst_cd", 32'(cd), 32'h00);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    reset = 1'b1; cwre = 1'b0;
    busy = 1'b0;
    repeat (8) begin
      tick();
      if (cbsy !== 1'b0 || txd !== 1'b1) busy = 1'b1;
    end
    chk("idle_after_reset", 32'(busy), 32'd0);

    cq = 8'h41; cwre = 1'b1;
    f = {1'b1, 8'h41, 1'b0};
    for (int i = 0; i < 10; i++) tx_exp.push_back(f[i]);
    tick();
    cwre = 1'b0;
    chk("tx_cbsy_rise", 32'(cbsy), 32'd1);
    cur = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) cur = tx_exp.pop_front();
      chk($sformatf("tx_bit%0d", i / 4), 32'(txd), 32'(cur));
      chk($sformatf("tx_busy%0d", i), 32'(cbsy), 32'd1);
      if (i == 10) begin
        cwre = 1'b1; cq = 8'hFF;
      end else begin
        cwre = 1'b0;
      end
      tick();
    end
    chk("tx_cbsy_fall", 32'(cbsy), 32'd0);
    chk("tx_idle_txd", 32'(txd), 32'd1);

    cq = 8'h3C; cwre = 1'b1;
    tick();
    cwre = 1'b0;
    chk("tx_accept_on_fall", 32'(cbsy), 32'd1);
    chk("tx2_start_bit", 32'(txd), 32'd0);
    w = 0;
    while (cbsy === 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk("tx2_busy_len", 32'(w), 32'd40);
    repeat (10) tick();
    chk("tx_no_extra", 32'(cbsy), 32'd0);

    send_frame(8'h5A, 1'b1, 1'b1);
    pop_check("rx_5a");
    chk("rx_pop_crda", 32'(crda), 32'd0);
    chk("rx_pop_cd", 32'(cd), 32'h00);
    chk("rx_ovr_quiet", 32'(ovr_cnt), 32'd0);
    chk("rx_ferr_quiet", 32'(ferr_cnt), 32'd0);

    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b1);
    chk("ovr_before_fifth", 32'(ovr_cnt), 32'd0);
    send_frame(8'h05, 1'b1, 1'b0);
    repeat (2) tick();
    chk("ovr_on_fifth", 32'(ovr_cnt), 32'd1);
    for (int b = 1; b <= 4; b++) pop_check($sformatf("ovr_pop%0d", b));
    chk("ovr_drained_crda", 32'(crda), 32'd0);
    chk("ovr_drained_cd", 32'(cd), 32'h00);

    send_frame(8'h33, 1'b0, 1'b0);
    repeat (4) tick();
    chk("ferr_pulse", 32'(ferr_cnt), 32'd1);
    chk("ferr_no_push", 32'(crda), 32'd0);

    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (40) tick();
    chk("glitch_ferr", 32'(ferr_cnt), 32'd1);
    chk("glitch_ovr", 32'(ovr_cnt), 32'd1);
    chk("glitch_no_push", 32'(crda), 32'd0);

    cq = 8'hC3; cwre = 1'b1;
    tick();
    cwre = 1'b0;
    rxd = 1'b0; repeat (CPB) tick();
    rxd = 1'b1; repeat (CPB) tick();
    rxd = 1'b0; repeat (CPB) tick();
    chk("mid_tx_active", 32'(cbsy), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_cbsy", 32'(cbsy), 32'd0);
    chk("mid_rst_crda", 32'(crda), 32'd0);
    chk("mid_rst_cd", 32'(cd), 32'h00);
    reset = 1'b1; rxd = 1'b1;
    repeat (60) tick();
    chk("post_rst_crda", 32'(crda), 32'd0);
    chk("post_rst_cbsy", 32'(cbsy), 32'd0);
    chk("post_rst_txd", 32'(txd), 32'd1);
    send_frame(8'hA5, 1'b1, 1'b1);
    pop_check("rx_a5");
    chk("rx_a5_drained", 32'(crda), 32'd0);
    chk("final_ferr", 32'(ferr_cnt), 32'd1);
    chk("final_ovr", 32'(ovr_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ext_uart_bridge.md
Name: ext_uart_bridge

Overview:
- I/O-side end of the core's EXT read and write ports.
- Receive path: deserialises UART bytes from `rxd` into a small FIFO, presents the head on `cd`/`crda`, and pops the head on `cack`.
- Transmit path: accepts a byte on `cq`/`cwre`, serialises it on `txd` (8N1, LSB first), and holds `cbsy` high until the stop bit has finished.
- Sits at top level between the core and the board UART pins.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Minimum 4.
- FIFO_AW, 2: RX FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cd  out  8  RX FIFO head byte to core
- crda  out  1  RX data available (FIFO not empty)
- cack  in  1  one-cycle pop strobe from core
- cq  in  8  byte to transmit
- cwre  in  1  one-cycle write strobe from core
- cbsy  out  1  transmitter busy
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output, idle high
- rx_overrun  out  1  one-cycle pulse: byte dropped, FIFO full
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0, byte dropped

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low, port named `reset`.
- Reset (`reset`=0 at a clock edge) gives: txd=1, cbsy=0, crda=0, cd=8'h00, rx_overrun=0, rx_frame_err=0. FIFO is emptied and both FSMs return to IDLE.
- Reset mid-operation aborts the frame in progress with no partial push and no partial transmission.
- Registers: all outputs are registered. `cd` is forced to 8'h00 whenever crda=0.
- Bit timer: counter width is clog2(CLKS_PER_BIT). Bit index is 3 bits and wraps 7 -> 0 only on the DATA -> STOP transition.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: cwre=1 latches cq into the shift register. On the following edge, cbsy=1, txd=0 and the FSM enters START.
- Each state lasts exactly CLKS_PER_BIT cycles.
- DATA shifts out 8 bits, LSB first.
- STOP drives txd=1. At the end of STOP the FSM returns to IDLE and cbsy=0 on the same edge.
- cbsy is high for exactly 10*CLKS_PER_BIT cycles per byte.
- cwre while cbsy=1 is ignored: the byte is dropped and the latched data is not disturbed.
- cwre is accepted on the same cycle cbsy falls, since the FSM is already IDLE.

RX path:
- rxd passes through a 2-flop synchroniser. Start is detected on a synchronised 1->0 edge in IDLE.
- START: sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE with no error.
- DATA: sample 8 bits at mid-bit, LSB first.
- STOP, sampled mid-bit:
  - 1: push to FIFO (or pulse rx_overrun if full), then return to IDLE.
  - 0: pulse rx_frame_err, discard the byte, return to IDLE.
- Return to IDLE happens at the stop mid-point, so back-to-back frames are received.

RX FIFO (first-word-fall-through):
- crda rises the cycle after the push edge, with cd valid on that same cycle.
- cack=1 while crda=1 pops one entry; cd/crda update on the next edge.
- cack while crda=0 is ignored.
- Push while full, no pop: the new byte is dropped and rx_overrun pulses. Existing contents are untouched.
- Push and pop on the same edge while full: both succeed and the count is unchanged. No overrun.
- Push and pop on the same edge while holding one entry: the new byte becomes the head and crda stays 1.
- Pointers are FIFO_AW bits wide and wrap modulo depth. The count is FIFO_AW+1 bits to distinguish full from empty.

Decomposition:
- Shared definitions go in Constants.v:
  - TX/RX state encodings, 2 bits: IDLE=0, START=1, DATA=2, STOP=3
  - UART_DATA_BITS=8
- One sub-module, ext_uart_fifo:
  - parameterised FIFO_AW, 8-bit wide, FWFT
  - ports: push/din/full, pop/dout/empty, overrun pulse
- TX and RX FSMs remain in ext_uart_bridge.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2):
- Reset: hold reset=0 for 3 cycles with rxd=1, cwre=1 -> txd=1, cbsy=0, crda=0, cd=8'h00. No transmission starts after release until a fresh cwre.
- TX: cwre pulse with cq=8'h41 -> cbsy=1 next edge. txd sends 0,1,0,0,0,0,0,1,0,1, each 4 cycles. cbsy=0 exactly 40 cycles after rising. A cwre with cq=8'hFF at cycle 10 is ignored.
- RX: drive 8'h5A serially -> crda=1 with cd=8'h5A. A one-cycle cack -> crda=0, cd=8'h00 next cycle. Flags stay 0.
- Overrun: send 8'h01..8'h05 back-to-back with no cack -> rx_overrun pulses once, on byte 5. Four cack pops return 01,02,03,04, then crda=0.
- Errors: a frame with stop bit 0 -> rx_frame_err pulses once and crda stays 0. A 1-cycle low glitch on rxd -> no flag and no push.
- Reset mid-frame: assert reset during TX DATA and RX DATA -> next edge txd=1, cbsy=0, FIFO empty. A subsequent clean 8'hA5 frame is received correctly.
